// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake between an ALU op producer and alu_op_sequencer.
// master = op producer / result consumer, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_error;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data, res_zero, res_error
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_zero, res_error
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time onto the adiabatic ALU, launching operands
// on a Bennett instruction boundary and capturing the result on the result-phase strobe.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_flag,
  input  logic             result_strobe,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ctrl0,
  output logic             alu_ctrl1,
  output logic             a_mux,
  output logic             b_mux0,
  output logic             b_mux1,
  output logic             adder_cin,
  output logic             sub,
  output logic             stl,
  output logic             mux3_0,
  output logic             mux3_1,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ARM, EVAL, RESP} state_t;

  typedef struct packed {
    logic ctrl1;
    logic ctrl0;
    logic sub;
    logic stl;
    logic cin;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] code);
    case (code)
      3'd0:    decode = ctrl_t'(5'b01000);
      3'd1:    decode = ctrl_t'(5'b01101);
      3'd2:    decode = ctrl_t'(5'b01011);
      3'd3:    decode = ctrl_t'(5'b00000);
      3'd4:    decode = ctrl_t'(5'b10000);
      3'd5:    decode = ctrl_t'(5'b11000);
      default: decode = ctrl_t'(5'b00000);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             inst_q, strobe_q;
  logic             inst_in, strobe_in, inst_rise, strobe_rise;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             op_ready_q, op_ready_d, res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d, res_error_q, res_error_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             accept, illegal, tmo_hit;

  // Anything other than a clean 1 (including X/Z) counts as low.
  assign inst_in     = (inst_flag === 1'b1);
  assign strobe_in   = (result_strobe === 1'b1);
  assign inst_rise   = inst_in & ~inst_q;
  assign strobe_rise = strobe_in & ~strobe_q;
  assign accept      = bus.op_valid & op_ready_q;
  assign illegal     = (bus.op_code > 3'd5);
  assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = illegal ? RESP : ARM;
      ARM:  if (inst_rise) state_d = EVAL;
      EVAL: if (strobe_rise || tmo_hit) state_d = RESP;
      RESP: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; ALU drive holds unless launched.
  always_comb begin
    code_d      = code_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    ctrl_d      = ctrl_q;
    tmo_d       = tmo_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_error_d = res_error_q;
    ops_d       = ops_q;
    op_ready_d  = (state_d == IDLE);
    res_valid_d = (state_d == RESP);
    case (state_q)
      IDLE: if (accept) begin
        code_d = bus.op_code;
        a_d    = bus.op_a;
        b_d    = bus.op_b;
        if (illegal) begin
          res_error_d = 1'b1;
          res_data_d  = '0;
          res_zero_d  = 1'b0;
        end
      end
      ARM: if (inst_rise) begin
        alu_a_d = a_q;
        alu_b_d = b_q;
        ctrl_d  = decode(code_q);
        tmo_d   = '0;
      end
      EVAL: begin
        if (strobe_rise) begin
          res_data_d  = alu_out;
          res_zero_d  = alu_zero;
          res_error_d = 1'b0;
          ops_d       = ops_q + CNT_W'(1);
        end else if (tmo_hit) begin
          res_error_d = 1'b1;
          res_data_d  = '0;
          res_zero_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q      <= 1'b0;
      strobe_q    <= 1'b0;
      code_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ctrl_q      <= '0;
      tmo_q       <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_error_q <= 1'b0;
      ops_q       <= '0;
    end else begin
      inst_q      <= inst_in;
      strobe_q    <= strobe_in;
      code_q      <= code_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      ctrl_q      <= ctrl_d;
      tmo_q       <= tmo_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_error_q <= res_error_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_error = res_error_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctrl1     = ctrl_q.ctrl1;
  assign alu_ctrl0     = ctrl_q.ctrl0;
  assign sub           = ctrl_q.sub;
  assign stl           = ctrl_q.stl;
  assign adder_cin     = ctrl_q.cin;
  assign a_mux         = 1'b0;
  assign b_mux0        = 1'b0;
  assign b_mux1        = 1'b0;
  assign mux3_0        = 1'b0;
  assign mux3_1        = 1'b0;
  assign ops_done      = ops_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and hand-driven
// Bennett instruction flag / result strobe.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_flag, result_strobe;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_ctrl0, alu_ctrl1, a_mux, b_mux0, b_mux1;
  logic        adder_cin, sub, stl, mux3_0, mux3_1, alu_zero;
  logic [15:0] ops_done;

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(.WIDTH(16), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inst_flag(inst_flag), .result_strobe(result_strobe),
    .bus(bus), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1), .a_mux(a_mux), .b_mux0(b_mux0),
    .b_mux1(b_mux1), .adder_cin(adder_cin), .sub(sub), .stl(stl),
    .mux3_0(mux3_0), .mux3_1(mux3_1), .alu_out(alu_out), .alu_zero(alu_zero),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: adder with operand inversion, carry-out, OR, AND.
  logic [16:0] wide_sum;
  always_comb begin
    wide_sum = 17'(alu_a) + 17'(alu_b);
    case ({alu_ctrl1, alu_ctrl0})
      2'b01:   alu_out = (stl ? ~alu_a : alu_a) + (sub ? ~alu_b : alu_b) + 16'(adder_cin);
      2'b00:   alu_out = {15'd0, wide_sum[16]};
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
    alu_zero = (alu_out == 16'd0);
  end

  typedef struct {
    logic [2:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  ctrl;   // {ctrl1, ctrl0, sub, stl, cin}
    logic [15:0] data;
    logic        zero;
    int          hold;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;
  logic [15:0] last_a = 16'd0;
  logic [15:0] last_b = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_bits();
    return {alu_ctrl1, alu_ctrl0, sub, stl, adder_cin};
  endfunction

  task automatic accept(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!bus.op_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("op_ready_wait", 32'(bus.op_ready), 32'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic pulse_inst();
    @(posedge clk); #1 inst_flag = 1'b1;
    @(posedge clk); #1 inst_flag = 1'b0;
  endtask

  task automatic pulse_strobe();
    @(posedge clk); #1 result_strobe = 1'b1;
    @(posedge clk); #1 result_strobe = 1'b0;
  endtask

  task automatic release_resp();
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_clear", 32'(bus.res_valid), 32'd0);
    chk("op_ready_back", 32'(bus.op_ready), 32'd1);
  endtask

  task automatic do_vector(input vec_t v);
    accept(v.code, v.a, v.b);
    @(negedge clk);
    chk("arm_op_ready", 32'(bus.op_ready), 32'd0);
    chk("arm_alu_a_hold", 32'(alu_a), 32'(last_a));
    pulse_inst();
    @(negedge clk);
    chk("load_alu_a", 32'(alu_a), 32'(v.a));
    chk("load_alu_b", 32'(alu_b), 32'(v.b));
    chk("load_ctrl", 32'(ctrl_bits()), 32'(v.ctrl));
    chk("eval_res_valid", 32'(bus.res_valid), 32'd0);
    last_a = v.a; last_b = v.b;
    pulse_strobe();
    exp_done++;
    @(negedge clk);
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("res_data", 32'(bus.res_data), 32'(v.data));
    chk("res_zero", 32'(bus.res_zero), 32'(v.zero));
    chk("res_error", 32'(bus.res_error), 32'd0);
    chk("ops_done", 32'(ops_done), 32'(exp_done));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_res_data", 32'(bus.res_data), 32'(v.data));
    end
    release_resp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{3'd0, 16'h0001, 16'h0002, 5'b01000, 16'h0003, 1'b0, 1};
    vecs[1] = '{3'd1, 16'h0001, 16'h0001, 5'b01101, 16'h0000, 1'b1, 1};
    vecs[2] = '{3'd2, 16'h0001, 16'h0001, 5'b01011, 16'h0000, 1'b1, 1};
    vecs[3] = '{3'd3, 16'hFFFF, 16'h0001, 5'b00000, 16'h0001, 1'b0, 1};
    vecs[4] = '{3'd4, 16'h0080, 16'h0040, 5'b10000, 16'h00C0, 1'b0, 5};
    vecs[5] = '{3'd5, 16'hFF00, 16'hFFFF, 5'b11000, 16'hFF00, 1'b0, 5};
    vecs[6] = '{3'd1, 16'h0005, 16'h0003, 5'b01101, 16'h0002, 1'b0, 1};
    vecs[7] = '{3'd2, 16'h0003, 16'h0005, 5'b01011, 16'h0002, 1'b0, 1};

    reset = 1'b1; inst_flag = 1'b0; result_strobe = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_ctrl", 32'(ctrl_bits()), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);

    for (int i = 0; i < 8; i++) do_vector(vecs[i]);

    // Illegal op: immediate error response, ALU drive untouched
    accept(3'd6, 16'h1234, 16'h5678);
    @(negedge clk);
    chk("ill_res_valid", 32'(bus.res_valid), 32'd1);
    chk("ill_res_error", 32'(bus.res_error), 32'd1);
    chk("ill_res_data", 32'(bus.res_data), 32'd0);
    chk("ill_alu_a", 32'(alu_a), 32'(last_a));
    chk("ill_alu_b", 32'(alu_b), 32'(last_b));
    chk("ill_ops_done", 32'(ops_done), 32'(exp_done));
    release_resp();

    // Unknown inst_flag must not launch the op
    accept(3'd0, 16'h0010, 16'h0020);
    inst_flag = 1'bx;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("x_alu_a_hold", 32'(alu_a), 32'(last_a));
    chk("x_op_ready", 32'(bus.op_ready), 32'd0);
    chk("x_res_valid", 32'(bus.res_valid), 32'd0);
    inst_flag = 1'b0;
    pulse_inst();
    @(negedge clk);
    chk("x_load_alu_a", 32'(alu_a), 32'h0010);
    last_a = 16'h0010; last_b = 16'h0020;
    pulse_strobe();
    exp_done++;
    @(negedge clk);
    chk("x_res_data", 32'(bus.res_data), 32'h0030);
    chk("x_ops_done", 32'(ops_done), 32'(exp_done));
    release_resp();

    // Strobe never arrives: abort after TIMEOUT clocks in EVAL
    accept(3'd4, 16'h0F00, 16'h00F0);
    pulse_inst();
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("tmo_clks", 32'(n), 32'd64);
    chk("tmo_res_error", 32'(bus.res_error), 32'd1);
    chk("tmo_res_data", 32'(bus.res_data), 32'd0);
    chk("tmo_ops_done", 32'(ops_done), 32'(exp_done));
    release_resp();

    // Reset while in EVAL
    accept(3'd0, 16'h0101, 16'h0202);
    pulse_inst();
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("mid_rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_ctrl", 32'(ctrl_bits()), 32'd0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_done = 0; last_a = 16'd0; last_b = 16'd0;
    do_vector(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
